// File: rtl/mem_pkg.sv
// Shared types and constants for the two-cache main-memory arbiter.
package mem_pkg;

  localparam int unsigned ADDR_W  = 32;
  localparam int unsigned BLOCK_W = 128;
  localparam int unsigned OFF_W   = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    RESP = 2'd3
  } arb_state_t;

  typedef enum logic {
    REQ_I = 1'b0,
    REQ_D = 1'b1
  } req_id_t;

  // Miss descriptor captured from the granted cache.
  typedef struct packed {
    logic               evict;
    logic [ADDR_W-1:0]  load_addr;
    logic [ADDR_W-1:0]  evict_addr;
    logic [BLOCK_W-1:0] evict_block;
  } miss_req_t;

  function automatic logic [ADDR_W-1:0] blk_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:OFF_W], OFF_W'(0)};
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin picker; bit 0 is the icache, bit 1 the dcache.
module rr_arb2
  import mem_pkg::*;
(
  input  logic [1:0] req_i,
  input  req_id_t    last_grant_i,
  output logic [1:0] grant_o,
  output logic       valid_o
);

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant_o = req_i;
    if (req_i == 2'b11) begin
      grant_o = (last_grant_i == REQ_I) ? 2'b10 : 2'b01;
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between icache and dcache: optional writeback,
// then block fill, then a one-cycle ready pulse to the granted cache.
module mem_arbiter
  import mem_pkg::*;
(
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_evict,
  input  logic [ADDR_W-1:0]  i_load_addr,
  input  logic [ADDR_W-1:0]  i_evict_addr,
  input  logic [BLOCK_W-1:0] i_evict_block,
  output logic               i_ready,
  input  logic               d_load,
  input  logic               d_evict,
  input  logic [ADDR_W-1:0]  d_load_addr,
  input  logic [ADDR_W-1:0]  d_evict_addr,
  input  logic [BLOCK_W-1:0] d_evict_block,
  output logic               d_ready,
  output logic [BLOCK_W-1:0] fill_block,
  output logic               mem_req,
  output logic               mem_we,
  output logic [ADDR_W-1:0]  mem_addr,
  output logic [BLOCK_W-1:0] mem_wdata,
  input  logic [BLOCK_W-1:0] mem_rdata,
  input  logic               mem_ack
);

  arb_state_t         state_q, state_d;
  req_id_t            id_q, id_d;
  req_id_t            last_q, last_d;
  miss_req_t          req_q, req_d;
  logic [1:0]         blank_q, blank_d;
  logic               i_ready_q, i_ready_d;
  logic               d_ready_q, d_ready_d;
  logic               mem_req_q, mem_req_d;
  logic               mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]  mem_addr_q, mem_addr_d;
  logic [BLOCK_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [BLOCK_W-1:0] fill_q, fill_d;

  logic [1:0]         elig_c;
  logic [1:0]         grant_c;
  logic               grant_vld_c;
  miss_req_t          sel_c;

  // A requester is masked for the one IDLE cycle after its ready pulse.
  assign elig_c = {d_load & ~blank_q[1], i_load & ~blank_q[0]};

  rr_arb2 u_rr_arb2 (
    .req_i        (elig_c),
    .last_grant_i (last_q),
    .grant_o      (grant_c),
    .valid_o      (grant_vld_c)
  );

  always_comb begin
    if (grant_c[1]) begin
      sel_c = '{evict: d_evict, load_addr: d_load_addr,
                evict_addr: d_evict_addr, evict_block: d_evict_block};
    end else begin
      sel_c = '{evict: i_evict, load_addr: i_load_addr,
                evict_addr: i_evict_addr, evict_block: i_evict_block};
    end
  end

  // Next state and next registered outputs.
  always_comb begin
    state_d     = state_q;
    id_d        = id_q;
    last_d      = last_q;
    req_d       = req_q;
    blank_d     = 2'b00;
    i_ready_d   = 1'b0;
    d_ready_d   = 1'b0;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    fill_d      = fill_q;

    case (state_q)
      IDLE: begin
        if (grant_vld_c) begin
          id_d      = grant_c[1] ? REQ_D : REQ_I;
          req_d     = sel_c;
          mem_req_d = 1'b1;
          if (sel_c.evict) begin
            state_d     = WB;
            mem_we_d    = 1'b1;
            mem_addr_d  = blk_align(sel_c.evict_addr);
            mem_wdata_d = sel_c.evict_block;
          end else begin
            state_d    = FILL;
            mem_addr_d = blk_align(sel_c.load_addr);
          end
        end
      end
      WB: begin
        mem_req_d = 1'b1;
        if (mem_ack) begin
          state_d    = FILL;
          mem_addr_d = blk_align(req_q.load_addr);
        end else begin
          mem_we_d = 1'b1;
        end
      end
      FILL: begin
        if (mem_ack) begin
          state_d   = RESP;
          fill_d    = mem_rdata;
          i_ready_d = (id_q == REQ_I);
          d_ready_d = (id_q == REQ_D);
        end else begin
          mem_req_d = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
        last_d  = id_q;
        blank_d = (id_q == REQ_D) ? 2'b10 : 2'b01;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      id_q        <= REQ_I;
      last_q      <= REQ_I;
      req_q       <= '0;
      blank_q     <= 2'b00;
      i_ready_q   <= 1'b0;
      d_ready_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      fill_q      <= '0;
    end else begin
      state_q     <= state_d;
      id_q        <= id_d;
      last_q      <= last_d;
      req_q       <= req_d;
      blank_q     <= blank_d;
      i_ready_q   <= i_ready_d;
      d_ready_q   <= d_ready_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      fill_q      <= fill_d;
    end
  end

  assign i_ready    = i_ready_q;
  assign d_ready    = d_ready_q;
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign fill_block = fill_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table plus hand sequences.
module tb_mem_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic         i_load, i_evict, d_load, d_evict;
  logic [31:0]  i_load_addr, i_evict_addr, d_load_addr, d_evict_addr;
  logic [127:0] i_evict_block, d_evict_block;
  logic         i_ready, d_ready;
  logic [127:0] fill_block;
  logic         mem_req, mem_we;
  logic [31:0]  mem_addr;
  logic [127:0] mem_wdata, mem_rdata;
  logic         mem_ack;

  mem_arbiter dut (
    .clk           (clk),
    .reset         (reset),
    .i_load        (i_load),
    .i_evict       (i_evict),
    .i_load_addr   (i_load_addr),
    .i_evict_addr  (i_evict_addr),
    .i_evict_block (i_evict_block),
    .i_ready       (i_ready),
    .d_load        (d_load),
    .d_evict       (d_evict),
    .d_load_addr   (d_load_addr),
    .d_evict_addr  (d_evict_addr),
    .d_evict_block (d_evict_block),
    .d_ready       (d_ready),
    .fill_block    (fill_block),
    .mem_req       (mem_req),
    .mem_we        (mem_we),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_rdata     (mem_rdata),
    .mem_ack       (mem_ack)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] Z   = 128'h0;
  localparam logic [127:0] PA5 = {16{8'hA5}};
  localparam logic [127:0] P5A = {16{8'h5A}};
  localparam logic [127:0] PC3 = {16{8'hC3}};
  localparam logic [127:0] P3C = {16{8'h3C}};
  localparam logic [127:0] VD  = {4{32'hDEAD_BEEF}};
  localparam logic [127:0] VI  = {4{32'h1111_2222}};

  typedef struct {
    logic         rst, il, ie, dl, de, ack;
    logic [127:0] rdata;
    logic         req, we;
    logic [31:0]  addr;
    logic         ir, dr;
    logic [127:0] wdata, fill;
  } vec_t;

  localparam int NV = 19;
  vec_t tbl [NV];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [291:0] got, input logic [291:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", name, got, exp);
    else n_pass++;
  endtask

  function automatic logic [291:0] obs();
    return {mem_req, mem_we, mem_addr, i_ready, d_ready, mem_wdata, fill_block};
  endfunction

  function automatic logic [291:0] ex(input logic req, input logic we, input logic [31:0] addr,
                                      input logic ir, input logic dr,
                                      input logic [127:0] wd, input logic [127:0] fl);
    return {req, we, addr, ir, dr, wd, fl};
  endfunction

  task automatic row(input int k, input logic rst, input logic il, input logic ie,
                     input logic dl, input logic de, input logic ack, input logic [127:0] rd,
                     input logic req, input logic we, input logic [31:0] addr,
                     input logic ir, input logic dr, input logic [127:0] wd, input logic [127:0] fl);
    tbl[k] = '{rst: rst, il: il, ie: ie, dl: dl, de: de, ack: ack, rdata: rd,
               req: req, we: we, addr: addr, ir: ir, dr: dr, wdata: wd, fill: fl};
  endtask

  initial begin
    int n_rdy;
    int n_ack;
    logic [127:0] exp_fill;
    logic [127:0] rd_pat;

    // inputs of row k drive cycle k; expected values are the outputs seen in cycle k
    row( 0, 0,1,0,0,0,0,Z,   0,0,32'h0,         0,0, Z,  Z);
    row( 1, 0,1,0,0,0,1,PA5, 1,0,32'h0000_1230, 0,0, Z,  Z);
    row( 2, 0,0,0,0,0,0,Z,   0,0,32'h0000_1230, 1,0, Z,  PA5);
    row( 3, 0,0,0,0,0,1,Z,   0,0,32'h0000_1230, 0,0, Z,  PA5);
    row( 4, 0,0,0,1,1,0,Z,   0,0,32'h0000_1230, 0,0, Z,  PA5);
    row( 5, 0,0,0,1,1,0,Z,   1,1,32'h0001_8040, 0,0, VD, PA5);
    row( 6, 0,0,0,1,1,0,Z,   1,1,32'h0001_8040, 0,0, VD, PA5);
    row( 7, 0,0,0,1,1,0,Z,   1,1,32'h0001_8040, 0,0, VD, PA5);
    row( 8, 0,0,0,1,1,1,Z,   1,1,32'h0001_8040, 0,0, VD, PA5);
    row( 9, 0,0,0,1,1,1,P5A, 1,0,32'h0002_0040, 0,0, VD, PA5);
    row(10, 0,0,0,0,0,0,Z,   0,0,32'h0002_0040, 0,1, VD, P5A);
    row(11, 1,0,0,0,0,0,Z,   0,0,32'h0002_0040, 0,0, VD, P5A);
    row(12, 0,1,0,1,0,0,Z,   0,0,32'h0,         0,0, Z,  Z);
    row(13, 0,1,0,1,0,1,PC3, 1,0,32'h0002_0040, 0,0, Z,  Z);
    row(14, 0,1,0,0,0,0,Z,   0,0,32'h0002_0040, 0,1, Z,  PC3);
    row(15, 0,1,0,0,0,0,Z,   0,0,32'h0002_0040, 0,0, Z,  PC3);
    row(16, 0,1,0,0,0,1,P3C, 1,0,32'h0000_1230, 0,0, Z,  PC3);
    row(17, 0,0,0,0,0,0,Z,   0,0,32'h0000_1230, 1,0, Z,  P3C);
    row(18, 0,0,0,0,0,0,Z,   0,0,32'h0000_1230, 0,0, Z,  P3C);

    reset = 1'b1;
    i_load = 1'b0; i_evict = 1'b0; d_load = 1'b0; d_evict = 1'b0;
    i_load_addr  = 32'h0000_1234; i_evict_addr = 32'h0000_5678;
    d_load_addr  = 32'h0002_0048; d_evict_addr = 32'h0001_8040;
    i_evict_block = VI; d_evict_block = VD;
    mem_rdata = Z; mem_ack = 1'b0;
    tick();
    tick();
    check("reset_state", obs(), ex(0, 0, 32'h0, 0, 0, Z, Z));

    // tests 1-3 plus spurious ack in IDLE, as a cycle table
    for (int k = 0; k < NV; k++) begin
      check($sformatf("vec%0d", k), obs(),
            ex(tbl[k].req, tbl[k].we, tbl[k].addr, tbl[k].ir, tbl[k].dr, tbl[k].wdata, tbl[k].fill));
      reset = tbl[k].rst;
      i_load = tbl[k].il; i_evict = tbl[k].ie;
      d_load = tbl[k].dl; d_evict = tbl[k].de;
      mem_ack = tbl[k].ack; mem_rdata = tbl[k].rdata;
      tick();
    end

    // test 4: both loads held; grants must alternate D,I,D,I,D,I
    reset = 1'b1; i_load = 1'b0; d_load = 1'b0; mem_ack = 1'b0;
    tick();
    reset = 1'b0; i_load = 1'b1; d_load = 1'b1;
    n_rdy = 0; n_ack = 0; exp_fill = Z;
    for (int c = 0; c < 60 && n_rdy < 6; c++) begin
      tick();
      if (i_ready || d_ready) begin
        check($sformatf("t4_grant%0d", n_rdy), {i_ready, d_ready},
              (n_rdy % 2 == 0) ? 2'b01 : 2'b10);
        check($sformatf("t4_fill%0d", n_rdy), fill_block, exp_fill);
        n_rdy++;
      end
      if (mem_req) begin
        rd_pat = {4{32'hC0DE_0000 + 32'(n_ack)}};
        mem_rdata = rd_pat; exp_fill = rd_pat; mem_ack = 1'b1;
        n_ack++;
      end else begin
        mem_ack = 1'b0;
      end
    end
    i_load = 1'b0; d_load = 1'b0; mem_ack = 1'b0;
    check("t4_count", 292'(n_rdy), 292'(6));

    // test 5: reset while in WB
    reset = 1'b1;
    tick();
    reset = 1'b0; i_load = 1'b1; i_evict = 1'b1;
    tick();
    check("t5_wb", obs(), ex(1, 1, 32'h0000_5670, 0, 0, VI, Z));
    reset = 1'b1; i_load = 1'b0; i_evict = 1'b0;
    tick();
    check("t5_after_rst", obs(), ex(0, 0, 32'h0, 0, 0, Z, Z));
    reset = 1'b0;
    tick();
    check("t5_idle0", obs(), ex(0, 0, 32'h0, 0, 0, Z, Z));
    tick();
    check("t5_idle1", obs(), ex(0, 0, 32'h0, 0, 0, Z, Z));
    d_load = 1'b1;
    tick();
    check("t5_new_fill", obs(), ex(1, 0, 32'h0002_0040, 0, 0, Z, Z));
    mem_ack = 1'b1; mem_rdata = PC3;
    tick();
    check("t5_new_ready", obs(), ex(0, 0, 32'h0002_0040, 0, 1, Z, PC3));

    // test 6: spurious ack in IDLE, then load dropped during FILL
    d_load = 1'b0; mem_ack = 1'b0;
    tick();
    check("t6_idle", obs(), ex(0, 0, 32'h0002_0040, 0, 0, Z, PC3));
    mem_ack = 1'b1; mem_rdata = P3C;
    tick();
    check("t6_spurious_ack", obs(), ex(0, 0, 32'h0002_0040, 0, 0, Z, PC3));
    mem_ack = 1'b0; d_load = 1'b1;
    tick();
    check("t6_fill", obs(), ex(1, 0, 32'h0002_0040, 0, 0, Z, PC3));
    d_load = 1'b0;
    tick();
    check("t6_fill_held", obs(), ex(1, 0, 32'h0002_0040, 0, 0, Z, PC3));
    mem_ack = 1'b1; mem_rdata = P5A;
    tick();
    mem_ack = 1'b0;
    check("t6_ready", obs(), ex(0, 0, 32'h0002_0040, 0, 1, Z, P5A));
    tick();
    check("t6_ready_once", obs(), ex(0, 0, 32'h0002_0040, 0, 0, Z, P5A));
    tick();
    check("t6_quiet", obs(), ex(0, 0, 32'h0002_0040, 0, 0, Z, P5A));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
